mii_char_checker: RTL and testbench

MII_CHAR_CHECKER -- requirements
Module: mii_char_checker

---
 rtl/mii_char_checker.sv | 183 ++++++++++++++++++
 tb/tb_mii_char_checker.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mii_char_checker.sv
// ============================================================================
//  Module      : mii_char_checker
//  Description : Per-lane MII character pattern checker with lock FSM and
//                saturating lane/word statistics, two-stage pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mii_char_checker #(
    parameter int          DATA_WIDTH        = 64,
    parameter logic [7:0]  DATA_CHAR_PATTERN = 8'hAA,
    parameter logic [7:0]  CTRL_CHAR_PATTERN = 8'h1C,
    parameter int          LOCK_COUNT        = 16,
    parameter int          UNLOCK_COUNT      = 4,
    parameter int          CNT_WIDTH         = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [DATA_WIDTH/8-1:0] ctrl_in,
    input  logic                    in_valid,
    input  logic                    clear,
    output logic                    locked,
    output logic                    err_word,
    output logic [CNT_WIDTH-1:0]    data_char_cnt,
    output logic [CNT_WIDTH-1:0]    ctrl_char_cnt,
    output logic [CNT_WIDTH-1:0]    err_char_cnt,
    output logic [CNT_WIDTH-1:0]    word_cnt
);

    localparam int c_LANES   = DATA_WIDTH / 8;
    localparam int c_PW      = $clog2(c_LANES + 1);
    localparam int c_RUN_MAX = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
    localparam int c_RUN_W   = $clog2(c_RUN_MAX + 1);

    localparam logic [0:0] c_HUNT   = 1'b0;
    localparam logic [0:0] c_LOCKED = 1'b1;

    // Popcount of a lane mask.
    function automatic logic [c_PW-1:0] popcnt(input logic [c_LANES-1:0] v);
        logic [c_PW-1:0] n;
        n = '0;
        for (int i = 0; i < c_LANES; i++) begin
            n = n + c_PW'(v[i]);
        end
        return n;
    endfunction

    // Add with clamp at all-ones; the extended sum exposes any carry-out.
    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [c_PW-1:0]      b);
        logic [CNT_WIDTH+c_PW-1:0] s;
        s = {{c_PW{1'b0}}, a} + {{CNT_WIDTH{1'b0}}, b};
        if (s > {{c_PW{1'b0}}, {CNT_WIDTH{1'b1}}}) begin
            return {CNT_WIDTH{1'b1}};
        end
        return s[CNT_WIDTH-1:0];
    endfunction

    logic [c_LANES-1:0] w_bad;

    generate
        for (genvar gi = 0; gi < c_LANES; gi++) begin : g_lane
            assign w_bad[gi] = ctrl_in[gi] ? (data_in[gi*8 +: 8] != CTRL_CHAR_PATTERN)
                                           : (data_in[gi*8 +: 8] != DATA_CHAR_PATTERN);
        end
    endgenerate

    // Stage 1: only the valid needs reset; bad/ctrl are qualified by it.
    logic               r_s1_valid;
    logic [c_LANES-1:0] r_s1_bad;
    logic [c_LANES-1:0] r_s1_ctrl;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= in_valid;
        end
        r_s1_bad  <= w_bad;
        r_s1_ctrl <= ctrl_in;
    end

    logic            w_s1_err;
    logic [c_PW-1:0] w_ctrl_pc;
    logic [c_PW-1:0] w_bad_pc;
    logic [c_PW-1:0] w_data_pc;

    assign w_s1_err  = |r_s1_bad;
    assign w_ctrl_pc = popcnt(r_s1_ctrl);
    assign w_bad_pc  = popcnt(r_s1_bad);
    assign w_data_pc = c_PW'(c_LANES) - w_ctrl_pc;

    // Stage 2: statistics and error pulse.
    logic [CNT_WIDTH-1:0] r_data_cnt;
    logic [CNT_WIDTH-1:0] r_ctrl_cnt;
    logic [CNT_WIDTH-1:0] r_err_cnt;
    logic [CNT_WIDTH-1:0] r_word_cnt;
    logic                 r_err_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_cnt <= '0;
            r_ctrl_cnt <= '0;
            r_err_cnt  <= '0;
            r_word_cnt <= '0;
            r_err_word <= 1'b0;
        end else begin
            r_err_word <= r_s1_valid & w_s1_err;
            if (clear) begin
                r_data_cnt <= '0;
                r_ctrl_cnt <= '0;
                r_err_cnt  <= '0;
                r_word_cnt <= '0;
            end else if (r_s1_valid) begin
                r_data_cnt <= sat_add(r_data_cnt, w_data_pc);
                r_ctrl_cnt <= sat_add(r_ctrl_cnt, w_ctrl_pc);
                r_err_cnt  <= sat_add(r_err_cnt, w_bad_pc);
                r_word_cnt <= sat_add(r_word_cnt, c_PW'(1));
            end
        end
    end

    // Lock FSM: one run counter, meaning depends on state (clean run in HUNT,
    // errored run in LOCKED).
    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_RUN_W-1:0] r_run;
    logic [c_RUN_W-1:0] w_run_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_HUNT;
            r_run   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= w_run_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        if (r_s1_valid) begin
            case (r_state)
                c_HUNT: begin
                    if (w_s1_err) begin
                        w_run_nxt = '0;
                    end else if (r_run == c_RUN_W'(LOCK_COUNT - 1)) begin
                        w_state_nxt = c_LOCKED;
                        w_run_nxt   = '0;
                    end else begin
                        w_run_nxt = r_run + c_RUN_W'(1);
                    end
                end
                c_LOCKED: begin
                    if (!w_s1_err) begin
                        w_run_nxt = '0;
                    end else if (r_run == c_RUN_W'(UNLOCK_COUNT - 1)) begin
                        w_state_nxt = c_HUNT;
                        w_run_nxt   = '0;
                    end else begin
                        w_run_nxt = r_run + c_RUN_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = c_HUNT;
                    w_run_nxt   = '0;
                end
            endcase
        end
    end

    assign locked        = (r_state == c_LOCKED);
    assign err_word      = r_err_word;
    assign data_char_cnt = r_data_cnt;
    assign ctrl_char_cnt = r_ctrl_cnt;
    assign err_char_cnt  = r_err_cnt;
    assign word_cnt      = r_word_cnt;

endmodule

`default_nettype wire

// File: tb/tb_mii_char_checker.sv
// ============================================================================
//  Module      : tb_mii_char_checker
//  Description : Directed, table-driven bench for mii_char_checker.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mii_char_checker;

    localparam logic [63:0] c_CLEAN = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] c_ERR0  = 64'hAAAA_AAAA_AAAA_AA00;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        rst2     = 1'b1;
    logic        clear    = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] data_in  = '0;
    logic [7:0]  ctrl_in  = '0;

    logic        locked, err_word;
    logic [31:0] data_char_cnt, ctrl_char_cnt, err_char_cnt, word_cnt;
    logic        locked2, err_word2;
    logic [3:0]  data_cnt2, ctrl_cnt2, err_cnt2, word_cnt2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mii_char_checker dut (
        .clk(clk), .rst(rst), .data_in(data_in), .ctrl_in(ctrl_in),
        .in_valid(in_valid), .clear(clear), .locked(locked), .err_word(err_word),
        .data_char_cnt(data_char_cnt), .ctrl_char_cnt(ctrl_char_cnt),
        .err_char_cnt(err_char_cnt), .word_cnt(word_cnt)
    );

    mii_char_checker #(.CNT_WIDTH(4)) dut_sat (
        .clk(clk), .rst(rst2), .data_in(data_in), .ctrl_in(ctrl_in),
        .in_valid(in_valid), .clear(clear), .locked(locked2), .err_word(err_word2),
        .data_char_cnt(data_cnt2), .ctrl_char_cnt(ctrl_cnt2),
        .err_char_cnt(err_cnt2), .word_cnt(word_cnt2)
    );

    typedef struct {
        logic [7:0]  ctrl;
        logic [63:0] data;
        logic        exp_err;
        int          exp_d;
        int          exp_c;
        int          exp_e;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic [7:0] c, input logic [63:0] d);
        in_valid = v;
        ctrl_in  = c;
        data_in  = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        put(1'b0, 8'h00, 64'h0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_cnts(input string name, input int d, input int c, input int e, input int w);
        chk({name, "_data"}, data_char_cnt, d);
        chk({name, "_ctrl"}, ctrl_char_cnt, c);
        chk({name, "_err"},  err_char_cnt, e);
        chk({name, "_word"}, word_cnt, w);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        logic       exp_e;
        int         pulses;

        vecs[0] = '{8'h00, c_CLEAN,                    1'b0, 8, 0, 0};
        vecs[1] = '{8'h81, 64'h1CAA_AAAA_AAAA_AA1C,    1'b0, 6, 2, 0};
        vecs[2] = '{8'h00, c_ERR0,                     1'b1, 8, 0, 1};
        vecs[3] = '{8'hFF, 64'h1C1C_1C1C_1C1C_1C1C,    1'b0, 0, 8, 0};
        vecs[4] = '{8'hFF, c_CLEAN,                    1'b1, 0, 8, 8};
        vecs[5] = '{8'h00, 64'h1C1C_1C1C_1C1C_1C1C,    1'b1, 8, 0, 8};
        vecs[6] = '{8'h0F, 64'hAAAA_AAAA_1C1C_1C1C,    1'b0, 4, 4, 0};
        vecs[7] = '{8'h0F, c_CLEAN,                    1'b1, 4, 4, 4};

        do_reset();
        chk("rst_locked", locked, 0);
        chk("rst_errword", err_word, 0);
        chk_cnts("rst", 0, 0, 0, 0);
        chk("rst_sat_word", word_cnt2, 0);

        // Each vector alone: clear, present word, result visible two edges later.
        for (int i = 0; i < 8; i++) begin
            clear = 1'b1;
            put(1'b0, 8'h00, 64'h0);
            tick();
            clear = 1'b0;
            put(1'b1, vecs[i].ctrl, vecs[i].data);
            tick();
            put(1'b0, 8'h00, 64'h0);
            tick();
            chk($sformatf("vec%0d_errword", i), err_word, vecs[i].exp_err);
            chk_cnts($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_c, vecs[i].exp_e, 1);
            tick();
            chk($sformatf("vec%0d_errpulse", i), err_word, 0);
        end

        // Lock acquisition with exact latency on the 16th clean word.
        do_reset();
        for (int k = 0; k < 15; k++) begin
            put(1'b1, 8'h00, c_CLEAN);
            tick();
        end
        put(1'b0, 8'h00, 64'h0);
        tick();
        tick();
        chk("hunt_after15", locked, 0);
        put(1'b1, 8'h00, c_CLEAN);
        tick();
        put(1'b0, 8'h00, 64'h0);
        chk("lock_latency", locked, 0);
        tick();
        chk("lock_16", locked, 1);
        for (int k = 0; k < 4; k++) begin
            put(1'b1, 8'h00, c_CLEAN);
            tick();
        end
        put(1'b0, 8'h00, 64'h0);
        tick();
        chk("lock_hold", locked, 1);
        chk_cnts("clean20", 160, 0, 0, 20);

        // Mixed control/data word.
        put(1'b1, 8'h81, 64'h1CAA_AAAA_AAAA_AA1C);
        tick();
        put(1'b0, 8'h00, 64'h0);
        tick();
        chk("mixed_errword", err_word, 0);
        chk_cnts("mixed", 166, 2, 0, 21);

        // Unlock: 3 errored, 1 clean, 4 errored.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk_cnts("clear_idle", 0, 0, 0, 0);
        pat    = 8'b1111_0111;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) put(1'b1, 8'h00, pat[i] ? c_ERR0 : c_CLEAN);
            else       put(1'b0, 8'h00, 64'h0);
            tick();
            if (i >= 1) begin
                exp_e = (i <= 8) ? pat[i-1] : 1'b0;
                chk($sformatf("unlock_errword_%0d", i), err_word, exp_e);
                chk($sformatf("unlock_locked_%0d", i), locked, (i <= 7) ? 1 : 0);
                if (err_word) pulses++;
            end
        end
        chk("unlock_pulses", pulses, 7);
        chk("unlock_errcnt", err_char_cnt, 7);

        // Gapped relock after a single error.
        do_reset();
        for (int k = 0; k < 15; k++) begin
            put(1'b1, 8'h00, c_CLEAN); tick();
            put(1'b0, 8'h00, 64'h0);   tick();
        end
        put(1'b1, 8'h00, c_ERR0); tick();
        put(1'b0, 8'h00, 64'h0);  tick();
        for (int k = 0; k < 15; k++) begin
            put(1'b1, 8'h00, c_CLEAN); tick();
            put(1'b0, 8'h00, 64'h0);   tick();
            put(1'b0, 8'h00, 64'h0);   tick();
        end
        tick();
        chk("gap_nolock", locked, 0);
        chk("gap_errcnt", err_char_cnt, 1);
        chk("gap_wordcnt", word_cnt, 31);
        put(1'b1, 8'h00, c_CLEAN); tick();
        put(1'b0, 8'h00, 64'h0);   tick();
        chk("gap_lock", locked, 1);

        // Clear while an errored word sits in stage 2.
        put(1'b1, 8'h00, c_ERR0);
        tick();
        clear = 1'b1;
        put(1'b0, 8'h00, 64'h0);
        tick();
        clear = 1'b0;
        chk("clear_s2_errword", err_word, 1);
        chk("clear_s2_locked", locked, 1);
        chk_cnts("clear_s2", 0, 0, 0, 0);

        // Reset in the same cycle as a valid word, then with a word in flight.
        put(1'b1, 8'h00, c_ERR0);
        rst   = 1'b1;
        clear = 1'b1;
        tick();
        rst   = 1'b0;
        clear = 1'b0;
        put(1'b0, 8'h00, 64'h0);
        tick();
        chk("rst_word_locked", locked, 0);
        chk("rst_word_errword", err_word, 0);
        chk_cnts("rst_word", 0, 0, 0, 0);
        put(1'b1, 8'h00, c_CLEAN);
        tick();
        rst = 1'b1;
        put(1'b0, 8'h00, 64'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("rst_flight_word", word_cnt, 0);

        // Saturation on the 4-bit build: each word adds 4 data, 4 ctrl, 8 err, 1 word.
        rst2 = 1'b1;
        tick();
        rst2 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            put(1'b1, 8'h0F, 64'h0);
            tick();
        end
        put(1'b0, 8'h00, 64'h0);
        tick();
        chk("sat2_data", data_cnt2, 8);
        chk("sat2_ctrl", ctrl_cnt2, 8);
        chk("sat2_err", err_cnt2, 15);
        chk("sat2_word", word_cnt2, 2);
        for (int k = 0; k < 18; k++) begin
            put(1'b1, 8'h0F, 64'h0);
            tick();
        end
        put(1'b0, 8'h00, 64'h0);
        tick();
        chk("sat20_data", data_cnt2, 4'hF);
        chk("sat20_ctrl", ctrl_cnt2, 4'hF);
        chk("sat20_err", err_cnt2, 4'hF);
        chk("sat20_word", word_cnt2, 4'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
